// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature encoder step/direction decoder with input filtering
//
// Purpose:
//   Synchronizes and debounces the two encoder channels, then decodes each
//   filtered Gray-code transition into a one-cycle step pulse plus direction.
//   Two-bit jumps are flagged as illegal in a sticky flag and a saturating count.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   quad_a     in   asynchronous encoder channel A
//   quad_b     in   asynchronous encoder channel B
//   clear_err  in   synchronous clear of err / err_count
//   up_down    out  direction of the last valid step (1 = up)
//   step       out  one-cycle pulse per valid transition
//   err        out  sticky illegal-transition flag
//   err_count  out  saturating count of illegal transitions

module quad_step_decoder #(
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quad_a,
  input  logic       quad_b,
  input  logic       clear_err,
  output logic       up_down,
  output logic       step,
  output logic       err,
  output logic [7:0] err_count
);

  localparam logic [3:0] FLEN      = 4'(FILTER_LEN);
  // INIT lasts FILTER_LEN+2 cycles: long enough for the synchronizer to settle
  localparam logic [4:0] INIT_LAST = 5'(FILTER_LEN + 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] init_cnt_q, init_cnt_d;

  // Channel vectors are packed {A, B}
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt_q, filt_d;
  logic [3:0] fcnt_q [2];
  logic [3:0] fcnt_d [2];
  logic [1:0] prev_q, prev_d;

  logic       step_q, step_d;
  logic       up_down_q, up_down_d;
  logic       err_q, err_d;
  logic [7:0] err_count_q, err_count_d;

  logic [1:0] pos_cur, pos_prev, delta;
  logic       illegal;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = 5'd0;
        end else begin
          init_cnt_d = init_cnt_q + 5'd1;
        end
      end
      default: begin
        init_cnt_d = 5'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-channel filter: the filtered level only follows sync2 after it has
  // disagreed for FILTER_LEN consecutive cycles. INIT bypasses the filter so
  // whatever static level is present after reset is adopted silently.
  // ---------------------------------------------------------------------------
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = fcnt_q[i];
      if (state_q == ST_INIT) begin
        filt_d[i] = sync2_q[i];
        fcnt_d[i] = 4'd0;
      end else if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] + 4'd1 == FLEN) begin
          filt_d[i] = sync2_q[i];
          fcnt_d[i] = 4'd0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end else begin
        fcnt_d[i] = 4'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (transition decode)
  // Gray position 00=0, 01=1, 11=2, 10=3; a position delta of +1 is up,
  // -1 is down and 2 means both channels moved at once.
  // ---------------------------------------------------------------------------
  assign pos_cur  = {filt_q[1], filt_q[1] ^ filt_q[0]};
  assign pos_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
  assign delta    = pos_cur - pos_prev;

  always_comb begin
    step_d      = 1'b0;
    up_down_d   = up_down_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    prev_d      = prev_q;
    illegal     = 1'b0;

    if (state_q == ST_INIT) begin
      prev_d = sync2_q;
    end else begin
      prev_d = filt_q;
      case (delta)
        2'd1: begin
          step_d    = 1'b1;
          up_down_d = 1'b1;
        end
        2'd3: begin
          step_d    = 1'b1;
          up_down_d = 1'b0;
        end
        2'd2: illegal = 1'b1;
        default: ;
      endcase
    end

    // A clear coinciding with an illegal transition restarts the count at 1
    if (clear_err) begin
      err_d       = illegal;
      err_count_d = {7'd0, illegal};
    end else if (illegal) begin
      err_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      filt_q      <= 2'b00;
      fcnt_q[0]   <= 4'd0;
      fcnt_q[1]   <= 4'd0;
      prev_q      <= 2'b00;
      step_q      <= 1'b0;
      up_down_q   <= 1'b1;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      sync1_q     <= {quad_a, quad_b};
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      fcnt_q[0]   <= fcnt_d[0];
      fcnt_q[1]   <= fcnt_d[1];
      prev_q      <= prev_d;
      step_q      <= step_d;
      up_down_q   <= up_down_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign up_down   = up_down_q;
  assign step      = step_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule
